// File: rtl/dp_ram_pkg.sv
// Shared types and the byte-merge helper for the dp_ram_be_init storage slice.
package dp_ram_pkg;

  typedef enum logic {READ_ASYNC = 1'b0, READ_SYNC = 1'b1} read_mode_e;
  typedef enum logic {IDLE_READY = 1'b0, CLEARING = 1'b1} clr_state_e;

  // Widest word the merge helper handles; callers zero-extend inputs and truncate the result.
  localparam int MERGE_MAX_DW = 1024;
  localparam int MERGE_MAX_BE = MERGE_MAX_DW / 8;

  function automatic logic [MERGE_MAX_DW-1:0] be_merge(
    input logic [MERGE_MAX_DW-1:0] old_word,
    input logic [MERGE_MAX_DW-1:0] new_word,
    input logic [MERGE_MAX_BE-1:0] be
  );
    logic [MERGE_MAX_DW-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MERGE_MAX_BE; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dp_ram_clear_ctrl.sv
// Clear-sweep sequencer: walks every word once after reset or on request,
// holding the RAM not-ready until the last word has been written.
module dp_ram_clear_ctrl
  import dp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_DEPTH     = 1024,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RI,
  input  logic                  Clear_SI,
  output logic                  Ready_SO,
  output logic                  ClrEn_SO,
  output logic [ADDR_WIDTH-1:0] ClrAddr_DO
);

  localparam clr_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEARING : IDLE_READY;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);

  clr_state_e            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE_READY: begin
        if (Clear_SI) begin
          state_next = CLEARING;
          cnt_next   = '0;
        end
      end
      CLEARING: begin
        if (cnt_reg == LAST_ADDR) begin
          state_next = IDLE_READY;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_next = RESET_STATE;
        cnt_next   = '0;
      end
    endcase
  end

  // Reset mid-sweep restarts from address 0 so the whole array is always covered.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      state_reg <= RESET_STATE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign Ready_SO   = (state_reg == IDLE_READY);
  assign ClrEn_SO   = (state_reg == CLEARING);
  assign ClrAddr_DO = cnt_reg;

endmodule

// File: rtl/dp_ram_be_init.sv
// Dual-port (1W/1R) RAM with byte enables, selectable read latency,
// write-to-read bypass and a hardware clear sweep for defined contents.
module dp_ram_be_init
  import dp_ram_pkg::*;
#(
  parameter int                  ADDR_WIDTH     = 10,
  parameter int                  DATA_DEPTH     = 1024,
  parameter int                  DATA_WIDTH     = 32,
  parameter int                  BE_WIDTH       = DATA_WIDTH / 8,
  parameter int                  READ_MODE      = 0,
  parameter int                  BYPASS         = 1,
  parameter int                  CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RI,
  input  logic                  Clear_SI,
  output logic                  Ready_SO,
  input  logic                  WrEn_SI,
  input  logic [BE_WIDTH-1:0]   WrBe_SI,
  input  logic [ADDR_WIDTH-1:0] WrAddr_DI,
  input  logic [DATA_WIDTH-1:0] WrData_DI,
  input  logic                  RdEn_SI,
  input  logic [ADDR_WIDTH-1:0] RdAddr_DI,
  output logic [DATA_WIDTH-1:0] RdData_DO,
  output logic                  RdValid_SO
);

  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH+1)'(DATA_DEPTH);

  function automatic logic [DATA_WIDTH-1:0] merge_word(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [BE_WIDTH-1:0]   be
  );
    return DATA_WIDTH'(be_merge(MERGE_MAX_DW'(old_word), MERGE_MAX_DW'(new_word),
                                MERGE_MAX_BE'(be)));
  endfunction

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

  logic                  ready, clr_en;
  logic [ADDR_WIDTH-1:0] clr_addr;

  dp_ram_clear_ctrl #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .DATA_DEPTH     (DATA_DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_ctrl (
    .Clk_CI     (Clk_CI),
    .Rst_RI     (Rst_RI),
    .Clear_SI   (Clear_SI),
    .Ready_SO   (ready),
    .ClrEn_SO   (clr_en),
    .ClrAddr_DO (clr_addr)
  );

  logic                  wr_in_range, rd_in_range, wr_accept, collision;
  logic [DATA_WIDTH-1:0] wr_old, rd_old, rd_word;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign wr_in_range = ({1'b0, WrAddr_DI} < DEPTH_LIMIT);
  assign rd_in_range = ({1'b0, RdAddr_DI} < DEPTH_LIMIT);
  assign wr_accept   = ready & WrEn_SI & wr_in_range;
  assign wr_old      = wr_in_range ? mem[WrAddr_DI] : '0;
  assign rd_old      = rd_in_range ? mem[RdAddr_DI] : '0;
  assign collision   = wr_accept & (WrAddr_DI == RdAddr_DI);
  assign rd_word     = ((BYPASS != 0) && collision) ? merge_word(rd_old, WrData_DI, WrBe_SI)
                                                    : rd_old;

  // The sweep owns the write port while clearing; user writes are dropped then.
  always_comb begin
    mem_we    = wr_accept;
    mem_waddr = WrAddr_DI;
    mem_wdata = merge_word(wr_old, WrData_DI, WrBe_SI);
    if (clr_en) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = INIT_VALUE;
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  generate
    if (READ_MODE == int'(READ_SYNC)) begin : g_sync_read
      logic                  rd_accept;
      logic [DATA_WIDTH-1:0] rdata_reg;
      logic                  rvalid_reg;

      assign rd_accept = RdEn_SI & ready;

      always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
          rdata_reg  <= '0;
          rvalid_reg <= 1'b0;
        end else begin
          rvalid_reg <= rd_accept;
          if (rd_accept) rdata_reg <= rd_word;
        end
      end

      assign RdData_DO  = rdata_reg;
      assign RdValid_SO = rvalid_reg;
    end else begin : g_async_read
      logic unused_rd_en;
      assign unused_rd_en = RdEn_SI;
      assign RdData_DO    = rd_word;
      assign RdValid_SO   = ready;
    end
  endgenerate

  assign Ready_SO = ready;

  always @(posedge Clk_CI) begin
    assert ((2**ADDR_WIDTH >= DATA_DEPTH) && (DATA_WIDTH % 8 == 0) &&
            (DATA_WIDTH <= MERGE_MAX_DW))
      else $error("dp_ram_be_init: inconsistent ADDR_WIDTH/DATA_DEPTH/DATA_WIDTH");
  end

endmodule

// File: tb/tb_dp_ram_be_init.sv
// Directed bench: three RAM variants share one stimulus stream; each output is
// compared against hand-computed values with immediate assertions.
module tb_dp_ram_be_init;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        wr_en;
  logic [3:0]  wr_be;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [3:0]  rd_addr;

  // b_*: registered read, write-first; f_*: registered read, read-first;
  // s_*: combinational read, 12 words, non-zero init word.
  logic        b_ready, b_valid, f_ready, f_valid, s_ready, s_valid;
  logic [31:0] b_rdata, f_rdata, s_rdata;

  localparam logic [31:0] S_INIT = 32'h0BAD_F00D;

  int checks   = 0;
  int failures = 0;

  dp_ram_be_init #(
    .ADDR_WIDTH(4), .DATA_DEPTH(16), .DATA_WIDTH(32), .READ_MODE(1),
    .BYPASS(1), .CLEAR_ON_RESET(1), .INIT_VALUE(32'h0)
  ) u_byp (
    .Clk_CI(clk), .Rst_RI(rst), .Clear_SI(clear), .Ready_SO(b_ready),
    .WrEn_SI(wr_en), .WrBe_SI(wr_be), .WrAddr_DI(wr_addr), .WrData_DI(wr_data),
    .RdEn_SI(rd_en), .RdAddr_DI(rd_addr), .RdData_DO(b_rdata), .RdValid_SO(b_valid)
  );

  dp_ram_be_init #(
    .ADDR_WIDTH(4), .DATA_DEPTH(16), .DATA_WIDTH(32), .READ_MODE(1),
    .BYPASS(0), .CLEAR_ON_RESET(1), .INIT_VALUE(32'h0)
  ) u_rfirst (
    .Clk_CI(clk), .Rst_RI(rst), .Clear_SI(clear), .Ready_SO(f_ready),
    .WrEn_SI(wr_en), .WrBe_SI(wr_be), .WrAddr_DI(wr_addr), .WrData_DI(wr_data),
    .RdEn_SI(rd_en), .RdAddr_DI(rd_addr), .RdData_DO(f_rdata), .RdValid_SO(f_valid)
  );

  dp_ram_be_init #(
    .ADDR_WIDTH(4), .DATA_DEPTH(12), .DATA_WIDTH(32), .READ_MODE(0),
    .BYPASS(1), .CLEAR_ON_RESET(1), .INIT_VALUE(S_INIT)
  ) u_small (
    .Clk_CI(clk), .Rst_RI(rst), .Clear_SI(clear), .Ready_SO(s_ready),
    .WrEn_SI(wr_en), .WrBe_SI(wr_be), .WrAddr_DI(wr_addr), .WrData_DI(wr_data),
    .RdEn_SI(rd_en), .RdAddr_DI(rd_addr), .RdData_DO(s_rdata), .RdValid_SO(s_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
    $display("chk %-20s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] b32(input logic b);
    return {31'b0, b};
  endfunction

  // Returns the number of edges until each variant reports ready (0 = never within bound).
  task automatic wait_ready(output int n_big, output int n_small);
    n_big   = 0;
    n_small = 0;
    for (int i = 1; i <= 64; i++) begin
      step();
      if (s_ready && n_small == 0) n_small = i;
      if (b_ready) begin
        n_big = i;
        break;
      end
    end
  endtask

  task automatic write_word(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    step();
    wr_en = 1'b0; wr_be = 4'h0;
  endtask

  // After a sweep: 16-word variants hold 0, the 12-word one holds its init word.
  task automatic readback_all(input string tag);
    for (int a = 0; a < 16; a++) begin
      rd_en = 1'b1; rd_addr = 4'(a);
      step();
      check({tag, "_byp"}, b_rdata, 32'h0);
      check({tag, "_small"}, s_rdata, (a < 12) ? S_INIT : 32'h0);
    end
    rd_en = 1'b0;
  endtask

  int nb, ns;

  initial begin
    rst = 1'b1; clear = 1'b0; wr_en = 1'b0; wr_be = 4'h0; wr_addr = 4'h0;
    wr_data = 32'h0; rd_en = 1'b0; rd_addr = 4'h0;
    step();

    // Reset state
    check("rst_b_ready", b32(b_ready), 32'h0);
    check("rst_b_valid", b32(b_valid), 32'h0);
    check("rst_b_rdata", b_rdata, 32'h0);
    check("rst_f_rdata", f_rdata, 32'h0);
    check("rst_s_ready", b32(s_ready), 32'h0);
    check("rst_s_valid", b32(s_valid), 32'h0);

    // 1: power-up sweep length and cleared contents
    rst = 1'b0;
    wait_ready(nb, ns);
    check("init_sweep_16", nb, 32'd16);
    check("init_sweep_12", ns, 32'd12);
    readback_all("init_rd");
    step();
    check("rdvalid_drop", b32(b_valid), 32'h0);

    // 2: byte-enable merge
    write_word(4'd3, 32'hAABB_CCDD, 4'b1111);
    write_word(4'd3, 32'h1122_3344, 4'b0101);
    rd_en = 1'b1; rd_addr = 4'd3;
    step();
    check("be_merge_sync", b_rdata, 32'hAA22_CC44);
    check("be_valid_pulse", b32(b_valid), 32'h1);
    check("be_merge_async", s_rdata, 32'hAA22_CC44);
    rd_en = 1'b0;
    step();
    check("be_valid_fall", b32(b_valid), 32'h0);
    check("be_rdata_hold", b_rdata, 32'hAA22_CC44);

    // 3: same-cycle write/read collision
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEAD_BEEF; wr_be = 4'b1111;
    rd_en = 1'b1; rd_addr = 4'd5;
    #1;
    check("coll_async_byp", s_rdata, 32'hDEAD_BEEF);
    step();
    wr_en = 1'b0;
    check("coll_sync_byp", b_rdata, 32'hDEAD_BEEF);
    check("coll_sync_rfirst", f_rdata, 32'h0);
    step();
    check("coll_rfirst_later", f_rdata, 32'hDEAD_BEEF);
    wr_en = 1'b1; wr_addr = 4'd6; wr_data = 32'h1234_5678; wr_be = 4'b0011;
    rd_addr = 4'd6;
    #1;
    check("coll_async_part", s_rdata, 32'h0BAD_5678);
    step();
    wr_en = 1'b0; wr_be = 4'h0; rd_en = 1'b0;
    check("coll_sync_part", b_rdata, 32'h0000_5678);
    check("coll_rfirst_part", f_rdata, 32'h0);

    // 6: out-of-range write/read on the 12-word variant
    write_word(4'd13, 32'hFFFF_FFFF, 4'b1111);
    rd_addr = 4'd13; #1;
    check("oor_read_13", s_rdata, 32'h0);
    rd_addr = 4'd12; #1;
    check("oor_read_12", s_rdata, 32'h0);
    rd_addr = 4'd11; #1;
    check("inrange_read_11", s_rdata, S_INIT);
    rd_addr = 4'd1; #1;
    check("no_alias_1", s_rdata, S_INIT);

    // 4: requested clear drops writes issued during the sweep
    for (int a = 0; a < 16; a++) write_word(4'(a), 32'h5A5A_5A5A, 4'b1111);
    rd_addr = 4'd7; #1;
    check("fill_async", s_rdata, 32'h5A5A_5A5A);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_ready_low", b32(b_ready), 32'h0);
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h1234_5678; wr_be = 4'b1111;
    rd_en = 1'b1; rd_addr = 4'd2;
    step();
    wr_en = 1'b0; wr_be = 4'h0; rd_en = 1'b0;
    check("clr_rdvalid_low", b32(b_valid), 32'h0);
    check("clr_rdata_held", b_rdata, 32'h0000_5678);
    check("clr_s_valid_low", b32(s_valid), 32'h0);
    // One sweep edge has already passed, so 15 (and 11) remain.
    wait_ready(nb, ns);
    check("clr_sweep_16", nb, 32'd15);
    check("clr_sweep_12", ns, 32'd11);
    readback_all("clr_rd");

    // 5: reset in the middle of a sweep restarts it
    for (int a = 0; a < 16; a++) write_word(4'(a), 32'h5A5A_5A5A, 4'b1111);
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 7; i++) step();
    rst = 1'b1;
    #1;
    check("midrst_ready", b32(b_ready), 32'h0);
    check("midrst_valid", b32(b_valid), 32'h0);
    check("midrst_rdata", b_rdata, 32'h0);
    step();
    rst = 1'b0;
    wait_ready(nb, ns);
    check("midrst_sweep_16", nb, 32'd16);
    check("midrst_sweep_12", ns, 32'd12);
    readback_all("midrst_rd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
